// File: rtl/i2c_four_byte_writer_if.sv
// ---------------------------------------------------------------------------
// i2c_four_byte_writer_if
// Bundles the request, status and dual SCL/SDA bus signals of the
// four-byte I2C writer.
//
//   enable_i   request; a 0->1 edge starts one write transaction
//   lines_i    bus select mask (bit0 = bus 0, bit1 = bus 1)
//   data12_i   bytes 1,2 ([15:8] first)
//   data34_i   bytes 3,4 ([15:8] first)
//   sda_i      sampled SDA pin level per bus (ACK readback)
//   scl_o      SCL per bus, 1 = released, 0 = pull low
//   sda_o      SDA per bus, same encoding
//   busy_o     transaction in progress
//   done_o     one-cycle end-of-transaction pulse
//   ack_err_o  sticky NACK flag for the last transaction
//
// Modport master: the writer engine (it masters the I2C buses).
// Modport slave : the feeding logic / pad side.
// ---------------------------------------------------------------------------
interface i2c_four_byte_writer_if;
   logic        enable_i;
   logic [1:0]  lines_i;
   logic [15:0] data12_i;
   logic [15:0] data34_i;
   logic [1:0]  sda_i;
   logic [1:0]  scl_o;
   logic [1:0]  sda_o;
   logic        busy_o;
   logic        done_o;
   logic        ack_err_o;

   modport master (
      input  enable_i,
      input  lines_i,
      input  data12_i,
      input  data34_i,
      input  sda_i,
      output scl_o,
      output sda_o,
      output busy_o,
      output done_o,
      output ack_err_o
   );

   modport slave (
      output enable_i,
      output lines_i,
      output data12_i,
      output data34_i,
      output sda_i,
      input  scl_o,
      input  sda_o,
      input  busy_o,
      input  done_o,
      input  ack_err_o
   );
endinterface

// File: rtl/i2c_four_byte_writer.sv
// ---------------------------------------------------------------------------
// i2c_four_byte_writer
// On a 0->1 edge of enable_i (while idle and with a non-zero bus mask) the
// block latches four bytes and the mask, then emits one I2C write:
// START, 4 x (8 data bits + ACK slot), STOP on every selected bus.
// Unselected buses stay released (scl=1, sda=1).
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous, active-high reset
//   bus        i2c_four_byte_writer_if.master (request, status, SCL/SDA)
//
// Parameter:
//   QTR_PERIOD clk_i cycles per quarter SCL bit period (2..65535)
// ---------------------------------------------------------------------------
module i2c_four_byte_writer #(
   parameter int unsigned QTR_PERIOD = 30
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   i2c_four_byte_writer_if.master        bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BIT   = 2'd2,
      ST_STOP  = 2'd3
   } state_e;

   localparam logic [15:0] QTR_LAST  = 16'(QTR_PERIOD - 1);
   localparam logic [5:0]  SLOT_LAST = 6'd35;

   // Every ninth slot (8, 17, 26, 35) is the ACK slot of a byte.
   function automatic logic is_ack_slot(input logic [5:0] slot);
      return (slot == 6'd8) || (slot == 6'd17) || (slot == 6'd26) || (slot == 6'd35);
   endfunction

   state_e      state_q,   state_d;
   logic        enable_q,  enable_d;
   logic [15:0] qcnt_q,    qcnt_d;
   logic [1:0]  qtr_q,     qtr_d;
   logic [5:0]  slot_q,    slot_d;
   logic [31:0] shift_q,   shift_d;
   logic [1:0]  lines_q,   lines_d;
   logic [1:0]  scl_q,     scl_d;
   logic [1:0]  sda_q,     sda_d;
   logic        busy_q,    busy_d;
   logic        done_q,    done_d;
   logic        ack_err_q, ack_err_d;

   logic        start_s;
   logic        tick_s;
   logic        nack_s;
   logic        scl_bus_s;
   logic        sda_bus_s;

   assign start_s = bus.enable_i & ~enable_q & (state_q == ST_IDLE) & (bus.lines_i != 2'b00);
   assign tick_s  = (state_q != ST_IDLE) && (qcnt_q == QTR_LAST);
   assign nack_s  = |(bus.sda_i & lines_q);

   // State register: all sequential state and the registered outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         enable_q  <= 1'b0;
         qcnt_q    <= 16'd0;
         qtr_q     <= 2'd0;
         slot_q    <= 6'd0;
         shift_q   <= 32'd0;
         lines_q   <= 2'b00;
         scl_q     <= 2'b11;
         sda_q     <= 2'b11;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         enable_q  <= enable_d;
         qcnt_q    <= qcnt_d;
         qtr_q     <= qtr_d;
         slot_q    <= slot_d;
         shift_q   <= shift_d;
         lines_q   <= lines_d;
         scl_q     <= scl_d;
         sda_q     <= sda_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         ack_err_q <= ack_err_d;
      end
   end

   // Next-state logic: sequencing of START / bit slots / STOP per quarter tick.
   always_comb begin
      state_d   = state_q;
      enable_d  = bus.enable_i;
      qtr_d     = qtr_q;
      slot_d    = slot_q;
      shift_d   = shift_q;
      lines_d   = lines_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;

      // Quarter counter only runs while a transaction is active.
      if (state_q == ST_IDLE) begin
         qcnt_d = 16'd0;
      end else if (tick_s) begin
         qcnt_d = 16'd0;
      end else begin
         qcnt_d = qcnt_q + 16'd1;
      end

      case (state_q)
         ST_IDLE: begin
            if (start_s) begin
               state_d   = ST_START;
               qtr_d     = 2'd0;
               slot_d    = 6'd0;
               lines_d   = bus.lines_i;
               shift_d   = {bus.data12_i, bus.data34_i};
               ack_err_d = 1'b0;
            end else begin
               state_d   = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s) begin
               if (qtr_q == 2'd3) begin
                  state_d = ST_BIT;
                  qtr_d   = 2'd0;
               end else begin
                  qtr_d   = qtr_q + 2'd1;
               end
            end else begin
               state_d = ST_START;
            end
         end
         ST_BIT: begin
            if (tick_s) begin
               // NACK is judged on the last cycle of Q2 of an ACK slot.
               if ((qtr_q == 2'd2) && is_ack_slot(slot_q) && nack_s) begin
                  ack_err_d = 1'b1;
               end else begin
                  ack_err_d = ack_err_q;
               end
               if (qtr_q == 2'd3) begin
                  qtr_d = 2'd0;
                  // ACK slots carry no data, so the shifter only moves after data slots.
                  if (is_ack_slot(slot_q)) begin
                     shift_d = shift_q;
                  end else begin
                     shift_d = {shift_q[30:0], 1'b0};
                  end
                  if (slot_q == SLOT_LAST) begin
                     state_d = ST_STOP;
                     slot_d  = 6'd0;
                  end else begin
                     slot_d  = slot_q + 6'd1;
                  end
               end else begin
                  qtr_d = qtr_q + 2'd1;
               end
            end else begin
               state_d = ST_BIT;
            end
         end
         ST_STOP: begin
            if (tick_s) begin
               if (qtr_q == 2'd3) begin
                  state_d = ST_IDLE;
                  qtr_d   = 2'd0;
                  done_d  = 1'b1;
               end else begin
                  qtr_d   = qtr_q + 2'd1;
               end
            end else begin
               state_d = ST_STOP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output logic: derived from next-state values so the registered pins
   // line up with the state they belong to.
   always_comb begin
      scl_bus_s = 1'b1;
      sda_bus_s = 1'b1;
      case (state_d)
         ST_IDLE: begin
            scl_bus_s = 1'b1;
            sda_bus_s = 1'b1;
         end
         ST_START: begin
            scl_bus_s = 1'b1;
            sda_bus_s = (qtr_d < 2'd2);
         end
         ST_BIT: begin
            scl_bus_s = qtr_d[1];
            sda_bus_s = is_ack_slot(slot_d) ? 1'b1 : shift_d[31];
         end
         ST_STOP: begin
            scl_bus_s = qtr_d[1];
            sda_bus_s = (qtr_d == 2'd3);
         end
         default: begin
            scl_bus_s = 1'b1;
            sda_bus_s = 1'b1;
         end
      endcase
      // Unselected buses are forced to the released level.
      scl_d  = {2{scl_bus_s}} | ~lines_d;
      sda_d  = {2{sda_bus_s}} | ~lines_d;
      busy_d = (state_d != ST_IDLE);
   end

   assign bus.scl_o     = scl_q;
   assign bus.sda_o     = sda_q;
   assign bus.busy_o    = busy_q;
   assign bus.done_o    = done_q;
   assign bus.ack_err_o = ack_err_q;

endmodule

// File: tb/tb_i2c_four_byte_writer.sv
module tb_i2c_four_byte_writer;

   localparam int Q        = 4;
   localparam int BUSY_LEN = 152 * Q;

   logic clk;
   logic rst;

   i2c_four_byte_writer_if ifc ();

   i2c_four_byte_writer #(.QTR_PERIOD(Q)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (ifc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic ack_err;
      int   busy_len;
   } done_t;

   // Scoreboard: expected SDA level at each SCL rising edge, per bus, and
   // expected status at each done pulse.
   logic  exp_bit0_q[$];
   logic  exp_bit1_q[$];
   done_t exp_done_q[$];
   int    exp_ack_rise = 0;
   logic  bcast_chk    = 1'b0;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic push_bit(input logic bi, input logic v);
      if (bi) exp_bit1_q.push_back(v);
      else    exp_bit0_q.push_back(v);
   endtask

   task automatic push_bus(input logic bi, input logic [31:0] word);
      logic [31:0] w;
      w = word;
      for (int by = 0; by < 4; by++) begin
         for (int i = 0; i < 8; i++) begin
            push_bit(bi, w[31]);
            w = {w[30:0], 1'b0};
         end
         push_bit(bi, 1'b1);          // ACK slot: SDA released
      end
      push_bit(bi, 1'b0);             // STOP: SCL rises with SDA low
   endtask

   task automatic push_exp(input logic [1:0] lines, input logic [15:0] d12, input logic [15:0] d34,
                           input logic fault, input logic with_done);
      done_t d;
      if (lines[0]) push_bus(1'b0, {d12, d34});
      if (lines[1]) push_bus(1'b1, {d12, d34});
      d.ack_err  = fault & lines[1];
      d.busy_len = BUSY_LEN;
      if (with_done) exp_done_q.push_back(d);
      exp_ack_rise = (fault && lines[1]) ? 27 : 0;
   endtask

   // Issue an enable pulse; returns at the negedge after the accepting edge.
   task automatic launch(input logic [1:0] lines, input logic [15:0] d12, input logic [15:0] d34);
      @(negedge clk);
      ifc.lines_i  = lines;
      ifc.data12_i = d12;
      ifc.data34_i = d34;
      ifc.enable_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("start_busy", 32'(ifc.busy_o), 32'd1);
      chk("ack_clr", 32'(ifc.ack_err_o), 32'd0);
      ifc.enable_i = 1'b0;
      ifc.data12_i = ~d12;
      ifc.data34_i = ~d34;
      ifc.lines_i  = ~lines;
   endtask

   // Hold sda_i[1] high for the whole 3rd ACK slot (slot 26).
   task automatic inject_nack();
      repeat (108 * Q - 1) @(posedge clk);
      @(negedge clk);
      ifc.sda_i[1] = 1'b1;
      repeat (4 * Q) @(posedge clk);
      @(negedge clk);
      ifc.sda_i[1] = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (ifc.done_o !== 1'b1 && t < BUSY_LEN + 100) begin
         @(negedge clk);
         t++;
      end
      if (ifc.done_o !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=%0d cycles expected=done", t);
      end
   endtask

   // Monitor state.
   int   cyc = 0;
   int   busy_cnt = 0;
   int   rise_cnt[2];
   int   last_rise[2];
   logic [1:0] scl_prev = 2'b11;
   logic [1:0] sda_prev = 2'b11;
   logic rst_prev  = 1'b1;
   logic busy_prev = 1'b0;
   logic done_prev = 1'b0;
   logic ack_prev  = 1'b0;

   task automatic mon_bus(input logic bi);
      logic e;
      int   qs;
      qs = bi ? exp_bit1_q.size() : exp_bit0_q.size();
      if (ifc.scl_o[bi] && !scl_prev[bi]) begin
         rise_cnt[bi]++;
         last_rise[bi] = cyc;
         checks++;
         if (qs == 0) begin
            errors++;
            $display("FAIL unexp_scl_rise bus%0d actual=rise expected=none", bi);
         end else begin
            if (bi) e = exp_bit1_q.pop_front();
            else    e = exp_bit0_q.pop_front();
            if (ifc.sda_o[bi] !== e) begin
               errors++;
               $display("FAIL sda_at_scl_rise bus%0d rise%0d actual=%0b expected=%0b",
                        bi, rise_cnt[bi], ifc.sda_o[bi], e);
            end
         end
      end else if (qs == 0 && ((!ifc.scl_o[bi] && scl_prev[bi]) || (!ifc.sda_o[bi] && sda_prev[bi]))) begin
         checks++;
         errors++;
         $display("FAIL idle_bus_activity bus%0d actual=scl%0b/sda%0b expected=1/1",
                  bi, ifc.scl_o[bi], ifc.sda_o[bi]);
      end
   endtask

   initial begin : monitor
      done_t d;
      rise_cnt  = '{0, 0};
      last_rise = '{0, 0};
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst && !rst_prev) begin
            if (ifc.busy_o && !busy_prev) begin
               rise_cnt = '{0, 0};
               busy_cnt = 0;
            end
            if (ifc.busy_o) busy_cnt++;
            mon_bus(1'b0);
            mon_bus(1'b1);
            if (bcast_chk && ifc.busy_o) begin
               checks++;
               if (ifc.scl_o[0] !== ifc.scl_o[1] || ifc.sda_o[0] !== ifc.sda_o[1]) begin
                  errors++;
                  $display("FAIL bcast_equal actual=scl%b sda%b expected=equal pairs", ifc.scl_o, ifc.sda_o);
               end
            end
            if (ifc.ack_err_o && !ack_prev) begin
               checks++;
               if (exp_ack_rise == 0 || rise_cnt[1] != exp_ack_rise || (cyc - last_rise[1]) != Q) begin
                  errors++;
                  $display("FAIL ack_err_rise actual=rise%0d/+%0d expected=rise%0d/+%0d",
                           rise_cnt[1], cyc - last_rise[1], exp_ack_rise, Q);
               end
            end
            if (ifc.done_o) begin
               checks++;
               if (done_prev) begin
                  errors++;
                  $display("FAIL done_width actual=2+ cycles expected=1");
               end else if (exp_done_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexp_done actual=pulse expected=none");
               end else begin
                  d = exp_done_q.pop_front();
                  if (busy_cnt != d.busy_len) begin
                     errors++;
                     $display("FAIL busy_len actual=%0d expected=%0d", busy_cnt, d.busy_len);
                  end
                  checks++;
                  if (ifc.ack_err_o !== d.ack_err) begin
                     errors++;
                     $display("FAIL done_ack_err actual=%0b expected=%0b", ifc.ack_err_o, d.ack_err);
                  end
                  checks++;
                  if (ifc.busy_o !== 1'b0) begin
                     errors++;
                     $display("FAIL done_busy actual=%0b expected=0", ifc.busy_o);
                  end
               end
            end
         end
         scl_prev  = ifc.scl_o;
         sda_prev  = ifc.sda_o;
         rst_prev  = rst;
         busy_prev = ifc.busy_o;
         done_prev = ifc.done_o;
         ack_prev  = ifc.ack_err_o;
      end
   end

   initial begin : stimulus
      rst          = 1'b1;
      ifc.enable_i = 1'b0;
      ifc.lines_i  = 2'b00;
      ifc.data12_i = 16'h0000;
      ifc.data34_i = 16'h0000;
      ifc.sda_i    = 2'b00;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("rst_scl", 32'(ifc.scl_o), 32'd3);
      chk("rst_sda", 32'(ifc.sda_o), 32'd3);
      chk("rst_busy", 32'(ifc.busy_o), 32'd0);
      chk("rst_done", 32'(ifc.done_o), 32'd0);
      chk("rst_ack_err", 32'(ifc.ack_err_o), 32'd0);

      // Bus 1 only.
      push_exp(2'b10, 16'hC060, 16'h8340, 1'b0, 1'b1);
      launch(2'b10, 16'hC060, 16'h8340);
      wait_done();

      // Broadcast: both buses identical.
      bcast_chk = 1'b1;
      push_exp(2'b11, 16'hC060, 16'h8340, 1'b0, 1'b1);
      launch(2'b11, 16'hC060, 16'h8340);
      wait_done();
      bcast_chk = 1'b0;

      // NACK in the 3rd ACK slot on selected bus 1.
      push_exp(2'b10, 16'hC060, 16'h8340, 1'b1, 1'b1);
      launch(2'b10, 16'hC060, 16'h8340);
      inject_nack();
      wait_done();
      repeat (5) @(negedge clk);
      chk("ack_sticky", 32'(ifc.ack_err_o), 32'd1);

      // Same NACK stimulus on an unselected bus; the start clears the flag.
      push_exp(2'b01, 16'h5AA5, 16'h3C96, 1'b1, 1'b1);
      launch(2'b01, 16'h5AA5, 16'h3C96);
      inject_nack();
      wait_done();

      // Enable held ~2000 cycles with a re-edge while busy: one transaction.
      push_exp(2'b10, 16'h1234, 16'h5678, 1'b0, 1'b1);
      @(negedge clk);
      ifc.lines_i  = 2'b10;
      ifc.data12_i = 16'h1234;
      ifc.data34_i = 16'h5678;
      ifc.enable_i = 1'b1;
      repeat (300) @(negedge clk);
      ifc.enable_i = 1'b0;
      @(negedge clk);
      ifc.enable_i = 1'b1;
      repeat (1700) @(negedge clk);
      ifc.enable_i = 1'b0;
      repeat (20) @(negedge clk);
      chk("one_txn", 32'(exp_done_q.size()), 32'd0);

      // Re-edge in the done cycle starts the next transaction.
      push_exp(2'b10, 16'hA55A, 16'h0FF0, 1'b0, 1'b1);
      launch(2'b10, 16'hA55A, 16'h0FF0);
      push_exp(2'b10, 16'h8001, 16'h7FFE, 1'b0, 1'b1);
      wait_done();
      ifc.lines_i  = 2'b10;
      ifc.data12_i = 16'h8001;
      ifc.data34_i = 16'h7FFE;
      ifc.enable_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("reedge_busy", 32'(ifc.busy_o), 32'd1);
      ifc.enable_i = 1'b0;
      wait_done();

      // Reset during byte 2 abandons the transaction.
      push_exp(2'b10, 16'hC060, 16'h8340, 1'b0, 1'b0);
      launch(2'b10, 16'hC060, 16'h8340);
      repeat (52 * Q) @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
      exp_bit0_q.delete();
      exp_bit1_q.delete();
      chk("midrst_scl", 32'(ifc.scl_o), 32'd3);
      chk("midrst_sda", 32'(ifc.sda_o), 32'd3);
      chk("midrst_busy", 32'(ifc.busy_o), 32'd0);
      chk("midrst_done", 32'(ifc.done_o), 32'd0);
      repeat (700) @(negedge clk);

      push_exp(2'b10, 16'hA55A, 16'h0FF0, 1'b0, 1'b1);
      launch(2'b10, 16'hA55A, 16'h0FF0);
      wait_done();

      // Edge with an empty mask is ignored.
      @(negedge clk);
      ifc.lines_i  = 2'b00;
      ifc.enable_i = 1'b1;
      @(negedge clk);
      ifc.enable_i = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         chk("nolines_busy", 32'(ifc.busy_o), 32'd0);
         chk("nolines_pins", 32'({ifc.scl_o, ifc.sda_o}), 32'hF);
      end

      repeat (10) @(negedge clk);
      chk("drain_bus0", 32'(exp_bit0_q.size()), 32'd0);
      chk("drain_bus1", 32'(exp_bit1_q.size()), 32'd0);
      chk("drain_done", 32'(exp_done_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_four_byte_writer.md
Name: i2c_four_byte_writer

Overview:
Downstream I2C engine fed by the HV/threshold looper. On a rising edge of its enable input it latches four bytes and a bus-select mask. It then emits one I2C write transaction (START, 4 bytes each followed by an ACK slot, STOP) on the selected pair(s) of two independent SCL/SDA buses. It reports busy, done and ACK-error status for monitoring.

Parameters:
QTR_PERIOD, 30, clk_i cycles per quarter SCL bit period (12 MHz / (4*30) = 100 kHz); legal range 2..65535

Ports:
clk_i  input  1  system clock; single clock domain
rst_i  input  1  synchronous, active-high reset
enable_i  input  1  a transaction request is its 0->1 edge; level is otherwise ignored
lines_i  input  2  bus select mask; bit0 = bus 0, bit1 = bus 1; both set = broadcast
data12_i  input  16  bytes 1,2; [15:8] sent first (address+R/W), then [7:0]
data34_i  input  16  bytes 3,4; [15:8] then [7:0]
sda_i  input  2  sampled SDA pin level per bus (open-drain readback) for ACK check
scl_o  output  2  SCL per bus; 1 = released (high-Z at pad), 0 = pull low
sda_o  output  2  SDA per bus; same encoding
busy_o  output  1  high while a transaction is in progress
done_o  output  1  one-cycle pulse at transaction end
ack_err_o  output  1  sticky; set if any selected bus returned NACK in any ACK slot

Behaviour:
- Reset (sync, any state): next edge -> scl_o=2'b11, sda_o=2'b11, busy_o=0, done_o=0, ack_err_o=0, state IDLE, quarter counter and bit counter cleared, enable edge register cleared. No STOP is generated; an interrupted transaction is abandoned.
- Edge detect: enable_q registered each cycle. start = enable_i & ~enable_q & (state==IDLE) & (lines_i!=0).
- Edges while busy are dropped and not queued. An edge with lines_i==0 is ignored: no busy, no done.
- On start: latch lines_i, data12_i, data34_i into a 32-bit shift register, clear ack_err_o. busy_o=1 from the next cycle.
- Timing: a quarter tick occurs every QTR_PERIOD cycles. Every phase below is 4 quarters, Q0..Q3.
- Unselected buses hold scl=1, sda=1 throughout.
- States: IDLE -> START -> BIT (36 bit slots: 4 bytes x (8 data + 1 ACK)) -> STOP -> IDLE.
- START: Q0,Q1: scl=1, sda=1. Q2,Q3: scl=1, sda=0.
- BIT, data slot: Q0: scl=0, sda=current MSB. Q1: scl=0. Q2,Q3: scl=1. Shift left at end of Q3. Bytes are sent MSB first, in the order data12[15:8], data12[7:0], data34[15:8], data34[7:0].
- BIT, ACK slot (every 9th): sda=1 (released) all quarters, scl as in a data slot. On the last cycle of Q2, for each selected bus, sda_i=1 sets ack_err_o. The transaction continues regardless of NACK.
- STOP: Q0,Q1: scl=0, sda=0. Q2: scl=1, sda=0. Q3: scl=1, sda=1.
- On the last cycle of STOP Q3: the next cycle has done_o=1, busy_o=0, state IDLE. A new edge may be accepted in that same cycle.
- Duration: busy_o is high for exactly 152*QTR_PERIOD cycles (4 START + 144 BIT + 4 STOP quarters).
- Counters: quarter counter 16 bit and wraps to 0 at QTR_PERIOD-1; bit slot counter 6 bit (0..35).
- Inputs changing during busy have no effect, since all inputs are latched at start.
- ack_err_o stays valid until the next accepted start or reset.

Test Plan:
- QTR_PERIOD=4, lines_i=2'b10, data12=16'hC060, data34=16'h8340, sda_i=0, pulse enable -> bus1 SCL-rising samples give bytes C0,60,83,40; ACK slots have sda_o=1; bus0 stays 1/1; busy_o high exactly 608 cycles; done_o one pulse; ack_err_o=0.
- Same stimulus with lines_i=2'b11 -> identical waveform on both buses, cycle-for-cycle.
- sda_i[1]=1 during the 3rd ACK slot only, lines_i=2'b10 -> ack_err_o rises at that slot's Q2 end, transaction completes, STOP emitted; the next start clears ack_err_o. With lines_i=2'b01, the same sda_i[1] stimulus leaves ack_err_o=0.
- enable_i held high for 2000 cycles, plus a second 0->1 edge mid-transaction -> exactly one transaction. An enable re-edge in the done_o cycle starts a new transaction (busy_o high the following cycle).
- rst_i asserted during byte 2 -> the next cycle has all scl/sda=1, busy_o=0, no done_o. A later enable edge runs a full, correct transaction.
- enable edge with lines_i=0 -> busy_o stays 0, no done_o, outputs stay 2'b11.
